// File: rtl/shift_lanes_pkg.sv
// -----------------------------------------------------------------------------
// shift_lanes_pkg
// Shared definitions for the multi-lane scrolling shift register.
//   mode_e         : step behaviour selected by the Mode input
//   DEFAULT_WIDTH  : default bits per lane
//   DEFAULT_LANES  : default number of lanes
//   DEFAULT_DIV_W  : default prescaler period width
// -----------------------------------------------------------------------------
package shift_lanes_pkg;

    localparam int DEFAULT_WIDTH = 6;
    localparam int DEFAULT_LANES = 2;
    localparam int DEFAULT_DIV_W = 8;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_ROT   = 2'b11
    } mode_e;

endpackage

// File: rtl/shift_lanes_prescaler.sv
// -----------------------------------------------------------------------------
// shift_lanes_prescaler
// Scroll-rate divider. While AutoEn is high it raises AutoTick once every
// Period+1 cycles; the count restarts from zero on reset, on Clear (parallel
// load) and whenever AutoEn is low.
// Ports:
//   Clk      : clock, rising edge
//   Rst      : synchronous reset, active low
//   Clear    : synchronous count clear (parallel load in the parent)
//   AutoEn   : prescaler enable
//   Period   : tick every Period+1 cycles
//   AutoTick : step request for the current cycle (derived from the count
//              register; the parent registers everything it drives out)
// -----------------------------------------------------------------------------
module shift_lanes_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clear,
    input  logic             AutoEn,
    input  logic [DIV_W-1:0] Period,
    output logic             AutoTick
);

    logic [DIV_W-1:0] count;

    // ">=" rather than "==" so that lowering Period below the running count
    // fires on the next cycle instead of wrapping around the full range.
    assign AutoTick = AutoEn && (count >= Period);

    always_ff @(posedge Clk) begin
        if (!Rst || Clear || !AutoEn) begin
            count <= '0;
        end else if (AutoTick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/shift_lanes.sv
// -----------------------------------------------------------------------------
// shift_lanes
// Multi-lane scrolling shift register between game control and the segment
// display driver. Every lane holds one row of content; the bit that falls out
// of a lane on each step is reported for collision/score logic.
// Optional feature: define SHIFT_LANES_AUTO_EN to build the internal
// scroll-rate prescaler. Without it, AutoEn/Period are accepted but ignored
// and steps come only from Shift.
// Ports:
//   Clk        : clock, rising edge
//   Rst        : synchronous reset, active low (loads RstValue)
//   RstValue   : per-lane reset contents, lane k at [k*WIDTH +: WIDTH]
//   BitIn      : serial input bit per lane
//   LaneEn     : lane takes part in steps when 1
//   Mode       : 00 hold, 01 shift left, 10 shift right, 11 rotate left
//   Shift      : manual step strobe
//   Load       : parallel load strobe (all lanes, wins over a step)
//   LoadData   : parallel load contents, same packing as RstValue
//   AutoEn     : enable prescaler steps
//   Period     : prescaler steps every Period+1 cycles
//   RegContent : lane contents, registered
//   ShiftOut   : bit that left each lane on its last step, registered
//   Tick       : one-cycle pulse the cycle after any step
// -----------------------------------------------------------------------------
module shift_lanes
    import shift_lanes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LANES = DEFAULT_LANES,
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [LANES*WIDTH-1:0] RstValue,
    input  logic [LANES-1:0]       BitIn,
    input  logic [LANES-1:0]       LaneEn,
    input  logic [1:0]             Mode,
    input  logic                   Shift,
    input  logic                   Load,
    input  logic [LANES*WIDTH-1:0] LoadData,
    input  logic                   AutoEn,
    input  logic [DIV_W-1:0]       Period,
    output logic [LANES*WIDTH-1:0] RegContent,
    output logic [LANES-1:0]       ShiftOut,
    output logic                   Tick
);

    logic  autoTick;
    logic  step;
    mode_e mode;

    assign mode = mode_e'(Mode);

`ifdef SHIFT_LANES_AUTO_EN
    shift_lanes_prescaler #(
        .DIV_W (DIV_W)
    ) uPrescaler (
        .Clk      (Clk),
        .Rst      (Rst),
        .Clear    (Load),
        .AutoEn   (AutoEn),
        .Period   (Period),
        .AutoTick (autoTick)
    );
`else
    logic unusedAuto;
    assign unusedAuto = ^{AutoEn, Period};
    assign autoTick   = 1'b0;
`endif

    // Manual and automatic requests merge into a single step.
    assign step = Shift | autoTick;

    // Tick reports that a step happened, even if no lane changed.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Tick <= 1'b0;
        end else if (Load) begin
            Tick <= 1'b0;
        end else begin
            Tick <= step;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : gLane
        logic [WIDTH-1:0] laneQ;
        logic             outQ;

        always_ff @(posedge Clk) begin
            if (!Rst) begin
                laneQ <= RstValue[k*WIDTH +: WIDTH];
                outQ  <= 1'b0;
            end else if (Load) begin
                // ShiftOut deliberately keeps the last shifted-out bit.
                laneQ <= LoadData[k*WIDTH +: WIDTH];
            end else if (step && LaneEn[k]) begin
                case (mode)
                    MODE_LEFT: begin
                        laneQ <= {laneQ[WIDTH-2:0], BitIn[k]};
                        outQ  <= laneQ[WIDTH-1];
                    end
                    MODE_RIGHT: begin
                        laneQ <= {BitIn[k], laneQ[WIDTH-1:1]};
                        outQ  <= laneQ[0];
                    end
                    MODE_ROT: begin
                        laneQ <= {laneQ[WIDTH-2:0], laneQ[WIDTH-1]};
                        outQ  <= laneQ[WIDTH-1];
                    end
                    default: begin
                        // Hold step: contents stay, nothing left the lane.
                        outQ  <= 1'b0;
                    end
                endcase
            end
        end

        assign RegContent[k*WIDTH +: WIDTH] = laneQ;
        assign ShiftOut[k]                  = outQ;
    end

endmodule
